// File: rtl/ipg_req_builder_pkg.sv
// ipg_req_builder_pkg: opcodes, header field positions and FSM states for ipg_req_builder
package ipg_req_builder_pkg;
  localparam logic [7:0] OP_READ  = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam int OP_MSB   = 63;
  localparam int OP_LSB   = 56;
  localparam int TAG_MSB  = 55;
  localparam int TAG_LSB  = 48;
  localparam int LEN_MSB  = 47;
  localparam int LEN_LSB  = 42;
  localparam int ADDR_MSB = 31;
  localparam int ADDR_LSB = 0;
  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
endpackage

// File: rtl/ipg_req_builder.sv
// ipg_req_builder: turns host read/write requests into header and data chunks for the PHY request queue
module ipg_req_builder
  import ipg_req_builder_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 6,
  parameter int MAX_LEN    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  tx_pause,
  output logic [DATA_WIDTH-1:0] ipg_req_chunk,
  output logic                  reqq_write,
  output logic                  busy,
  output logic                  req_err
);
  state_t                state;
  logic                  is_write;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  len;
  logic [LEN_WIDTH-1:0]  cnt;
  logic [7:0]            tag;
  logic [DATA_WIDTH-1:0] hdr;
  logic                  accept;
  logic                  illegal;
  logic                  wxfer;
  assign req_ready   = state == IDLE;
  assign wdata_ready = state == DATA && !tx_pause;
  assign busy        = state != IDLE;
  assign accept      = req_valid && req_ready;
  assign illegal     = req_len == '0 || req_len > LEN_WIDTH'(MAX_LEN);
  assign wxfer       = wdata_valid && wdata_ready;
  // header word assembled from the latched request and the current tag
  always_comb begin
    hdr                    = '0;
    hdr[OP_MSB:OP_LSB]     = is_write ? OP_WRITE : OP_READ;
    hdr[TAG_MSB:TAG_LSB]   = tag;
    hdr[LEN_MSB:LEN_LSB]   = len;
    hdr[ADDR_MSB:ADDR_LSB] = addr;
  end
  // request FSM with registered chunk, push strobe and error pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= IDLE;
      is_write      <= 1'b0;
      addr          <= '0;
      len           <= '0;
      cnt           <= '0;
      tag           <= '0;
      ipg_req_chunk <= '0;
      reqq_write    <= 1'b0;
      req_err       <= 1'b0;
    end else begin
      reqq_write <= 1'b0;
      req_err    <= accept && illegal;
      case (state)
        IDLE: if (accept && !illegal) begin
          is_write <= req_is_write;
          addr     <= req_addr;
          len      <= req_len;
          state    <= HDR;
        end
        HDR: if (!tx_pause) begin
          ipg_req_chunk <= hdr;
          reqq_write    <= 1'b1;
          tag           <= tag + 8'd1;
          cnt           <= len;
          state         <= is_write ? DATA : IDLE;
        end
        DATA: if (wxfer) begin
          ipg_req_chunk <= wdata;
          reqq_write    <= 1'b1;
          cnt           <= cnt - LEN_WIDTH'(1);
          state         <= cnt == LEN_WIDTH'(1) ? IDLE : DATA;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ipg_req_builder.sv
// tb_ipg_req_builder: directed stimulus with a request-level scoreboard model for ipg_req_builder
module tb_ipg_req_builder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [5:0]  req_len = '0;
  logic        wdata_valid = 1'b0;
  logic        wdata_ready;
  logic [63:0] wdata = '0;
  logic        tx_pause = 1'b0;
  logic [63:0] ipg_req_chunk;
  logic        reqq_write;
  logic        busy;
  logic        req_err;
  int vectors = 0;
  int miscompares = 0;
  ipg_req_builder dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_write(req_is_write), .req_addr(req_addr), .req_len(req_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .tx_pause(tx_pause), .ipg_req_chunk(ipg_req_chunk), .reqq_write(reqq_write),
    .busy(busy), .req_err(req_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // request-level model: one outstanding request, header then len data words for writes
  logic        m_pend = 1'b0;
  logic        m_w = 1'b0;
  logic [7:0]  m_tag = '0;
  logic [5:0]  m_len = '0;
  logic [31:0] m_addr = '0;
  int          m_left = 0;
  logic        e_push = 1'b0;
  logic        e_err = 1'b0;
  logic [63:0] e_chunk = '0;
  logic [63:0] last_chunk = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_chunk", ipg_req_chunk, 0);
      chk("rst_reqq_write", reqq_write, 0);
      chk("rst_req_err", req_err, 0);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_wdata_ready", wdata_ready, 0);
      chk("rst_busy", busy, 0);
      m_pend = 0; m_left = 0; m_tag = 0; e_push = 0; e_err = 0; last_chunk = 0;
    end else begin
      chk("m_busy", busy, m_pend || m_left > 0);
      chk("m_req_ready", req_ready, !(m_pend || m_left > 0));
      chk("m_wdata_ready", wdata_ready, !m_pend && m_left > 0 && !tx_pause);
      chk("m_reqq_write", reqq_write, e_push);
      chk("m_chunk", ipg_req_chunk, e_push ? e_chunk : last_chunk);
      chk("m_req_err", req_err, e_err);
      last_chunk = e_push ? e_chunk : last_chunk;
      e_push = 0;
      e_err = 0;
      if (m_pend) begin
        if (!tx_pause) begin
          e_push = 1;
          e_chunk = {m_w ? 8'h02 : 8'h01, m_tag, m_len, 10'd0, m_addr};
          m_tag++;
          m_pend = 0;
          m_left = m_w ? int'(m_len) : 0;
        end
      end else if (m_left > 0) begin
        if (wdata_valid && !tx_pause) begin
          e_push = 1;
          e_chunk = wdata;
          m_left--;
        end
      end else if (req_valid) begin
        if (req_len == 0 || req_len > 32) e_err = 1;
        else begin
          m_pend = 1; m_w = req_is_write; m_len = req_len; m_addr = req_addr;
        end
      end
    end
  end
  task automatic issue(input logic w, input logic [31:0] a, input logic [5:0] l);
    int g = 0;
    while (busy && g < 100) begin @(posedge clk); #1; g++; end
    if (busy) chk("idle_timeout", busy, 0);
    req_valid = 1; req_is_write = w; req_addr = a; req_len = l;
    @(posedge clk); #1;
    req_valid = 0;
  endtask
  task automatic wait_push(input string name, input logic [63:0] exp, output int lat);
    lat = 0;
    while (!reqq_write && lat < 50) begin @(posedge clk); #1; lat++; end
    chk({name, "_seen"}, reqq_write, 1);
    chk(name, ipg_req_chunk, exp);
  endtask
  task automatic send_words(input int n, input logic [63:0] base);
    int i = 0;
    int g = 0;
    wdata = base; wdata_valid = 1;
    while (i < n && g < 200) begin
      @(negedge clk);
      g++;
      if (wdata_ready) i++;
      @(posedge clk); #1;
      wdata = base + 64'(i);
    end
    if (i < n) chk("wdata_timeout", i, n);
    wdata_valid = 0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", req_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_chunk", ipg_req_chunk, 0);
    rst_n = 1;
    // read, tag 0
    issue(0, 32'h1000_0040, 4);
    chk("rd_accept_busy", busy, 1);
    wait_push("rd_hdr", 64'h0100_1000_1000_0040, lat);
    chk("rd_latency", lat, 1);
    @(posedge clk); #1;
    chk("rd_idle", busy, 0);
    chk("rd_single_push", reqq_write, 0);
    chk("rd_chunk_hold", ipg_req_chunk, 64'h0100_1000_1000_0040);
    // write len 3, tag 1, back-to-back data
    issue(1, 32'h2000_0000, 3);
    wait_push("wr_hdr", 64'h0201_0C00_2000_0000, lat);
    fork
      send_words(3, 64'hA1);
      for (int k = 1; k <= 3; k++) begin
        @(posedge clk); #1;
        chk("wr_b2b_push", reqq_write, 1);
        chk("wr_word", ipg_req_chunk, 64'hA0 + 64'(k));
      end
    join
    chk("wr_done_busy", busy, 0);
    // write len 4, tag 2, paused in HDR and mid-DATA
    issue(1, 32'h3000_0010, 4);
    tx_pause = 1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("hdr_pause_push", reqq_write, 0);
      chk("hdr_pause_wready", wdata_ready, 0);
    end
    tx_pause = 0;
    wait_push("pause_hdr", 64'h0202_1000_3000_0010, lat);
    fork
      send_words(4, 64'hB1);
      begin
        repeat (2) @(posedge clk);
        #1 tx_pause = 1;
        repeat (5) begin
          @(posedge clk); #1;
          chk("data_pause_push", reqq_write, 0);
          chk("data_pause_wready", wdata_ready, 0);
        end
        tx_pause = 0;
      end
    join
    chk("pause_last_word", ipg_req_chunk, 64'hB4);
    chk("pause_done_busy", busy, 0);
    // illegal lengths
    issue(0, 32'h50, 0);
    chk("err_len0", req_err, 1);
    chk("err_len0_idle", busy, 0);
    @(posedge clk); #1;
    chk("err_len0_pulse", req_err, 0);
    issue(0, 32'h60, 33);
    chk("err_len33", req_err, 1);
    chk("err_no_push", reqq_write, 0);
    issue(0, 32'h40, 1);
    wait_push("after_err_tag", 64'h0103_0400_0000_0040, lat);
    // reset after 2nd of 4 write words
    issue(1, 32'h7000_0000, 4);
    wait_push("rst_wr_hdr", 64'h0204_1000_7000_0000, lat);
    send_words(2, 64'hC1);
    #1 rst_n = 0;
    #1;
    chk("async_rst_chunk", ipg_req_chunk, 0);
    chk("async_rst_reqq_write", reqq_write, 0);
    chk("async_rst_req_ready", req_ready, 1);
    chk("async_rst_wdata_ready", wdata_ready, 0);
    chk("async_rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    // 256 reads from tag 0 after reset, then wrap
    for (int i = 0; i < 256; i++) begin
      issue(0, 32'(i), 1);
      wait_push("seq_hdr", {8'h01, 8'(i), 6'd1, 10'd0, 32'(i)}, lat);
    end
    issue(0, 32'h100, 1);
    wait_push("tag_wrap", 64'h0100_0400_0000_0100, lat);
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ipg_req_builder.md
IPG_REQ_BUILDER -- requirements
Module: ipg_req_builder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning request chunk width (matches PHY ipg_req_chunk).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning remote memory address width.
REQ-003 SHALL have parameter LEN_WIDTH, default 6, meaning word-count field width.
REQ-004 SHALL have parameter MAX_LEN, default 32, meaning largest legal word count.
REQ-005 clk  in  1  single clock for the block; this is the PHY tx_clk.
REQ-006 rst_n  in  1  reset, asynchronous and active-low.
REQ-007 req_valid  in  1  host request valid.
REQ-008 req_ready  out  1  host request accepted when high with req_valid.
REQ-009 req_is_write  in  1  1 = write request, 0 = read request.
REQ-010 req_addr  in  ADDR_WIDTH  target address.
REQ-011 req_len  in  LEN_WIDTH  number of 64-bit words.
REQ-012 wdata_valid  in  1  write-data word valid.
REQ-013 wdata_ready  out  1  write-data word accepted when high with wdata_valid.
REQ-014 wdata  in  DATA_WIDTH  write-data word.
REQ-015 tx_pause  in  1  PHY request-queue backpressure.
REQ-016 ipg_req_chunk  out  DATA_WIDTH  chunk to the PHY request queue.
REQ-017 reqq_write  out  1  one-cycle push strobe qualifying ipg_req_chunk.
REQ-018 busy  out  1  high in any state other than IDLE.
REQ-019 req_err  out  1  one-cycle pulse on rejection of an illegal request.

Function
REQ-020 The FSM SHALL have the states IDLE, HDR and DATA.
REQ-021 req_ready SHALL be 1 only in IDLE; on req_valid&&req_ready the FSM SHALL latch is_write, addr and len.
REQ-022 On acceptance with len==0 or len>MAX_LEN, the FSM SHALL drop the request, stay in IDLE, pulse req_err the next cycle, and leave the tag unchanged.
REQ-023 On a legal acceptance the FSM SHALL move to HDR.
REQ-024 Header format SHALL be: [63:56] opcode (0x01 read, 0x02 write), [55:48] tag, [47:42] len, [41:32] zero, [31:0] addr.
REQ-025 In HDR with tx_pause=0, the block SHALL register the header and assert reqq_write for exactly one cycle at the next edge.
REQ-026 After the header, the tag SHALL increment modulo 256 (255 wraps to 0).
REQ-027 After the header, the FSM SHALL go to DATA for a write and to IDLE for a read.
REQ-028 In HDR with tx_pause=1, the FSM SHALL hold with no push.
REQ-029 wdata_ready SHALL equal (state==DATA) && !tx_pause.
REQ-030 On each wdata transfer, the block SHALL register wdata onto ipg_req_chunk, pulse reqq_write and decrement the remaining-word count.
REQ-031 The transfer of the last word SHALL return the FSM to IDLE.
REQ-032 In DATA with wdata_valid=0 or tx_pause=1, the block SHALL make no push and hold the count.
REQ-033 Latency: a legal request accepted at edge N with tx_pause=0 SHALL give reqq_write high in cycle N+2 (header).
REQ-034 Write-data words SHALL be pushed back-to-back, one per cycle, while wdata_valid=1 and tx_pause=0.
REQ-035 reqq_write SHALL never be asserted in two consecutive cycles for the same chunk.
REQ-036 ipg_req_chunk SHALL hold its last value when reqq_write=0.
REQ-037 tx_pause rising in the same cycle as a DATA transfer SHALL block that transfer, since wdata_ready drops combinationally.

Reset
REQ-038 rst_n low SHALL asynchronously force state=IDLE, tag=0, remaining count=0, ipg_req_chunk=0, reqq_write=0 and req_err=0, giving req_ready=1, wdata_ready=0 and busy=0.
REQ-039 A reset mid-request SHALL discard the request silently, with no partial chunk pushed after deassertion.

Structure
REQ-040 A shared package SHALL hold the opcode constants (OP_READ=0x01, OP_WRITE=0x02), the header field bit positions and the FSM state enum.
REQ-041 The block SHALL be a single flat module with no sub-module.

Verification
REQ-042 Read request addr=0x1000_0040, len=4, tx_pause=0 -> one push 0x0100_1000_1000_0040 in cycle N+2, then IDLE, and tag becomes 1.
REQ-043 Write request len=3 with wdata 0xA1, 0xA2, 0xA3 streamed continuously -> 4 consecutive pushes (header opcode 0x02, len=3, then 0xA1, 0xA2, 0xA3), then busy=0.
REQ-044 tx_pause=1 for 5 cycles during HDR and again mid-DATA -> no pushes while paused, wdata_ready=0, and the word order is preserved after release.
REQ-045 len=0, then len=33 -> two req_err pulses, no reqq_write, and the tag is unchanged.
REQ-046 256 legal reads -> the tag in the 257th header equals 0x00.
REQ-047 rst_n asserted after the 2nd of 4 write words -> outputs are at reset values immediately, and after release the next read header carries tag 0.
